// File: rtl/rv32i_types_pkg.sv
// Shared RV32I encoding types: opcode/funct3 enums, instruction format structs,
// and the request/state types used by the instruction sequencer.
package rv32i_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [6:0] {
      OPC_LOAD     = 7'b0000011,
      OPC_MISC_MEM = 7'b0001111,
      OPC_OP_IMM   = 7'b0010011,
      OPC_AUIPC    = 7'b0010111,
      OPC_STORE    = 7'b0100011,
      OPC_OP       = 7'b0110011,
      OPC_LUI      = 7'b0110111,
      OPC_BRANCH   = 7'b1100011,
      OPC_JALR     = 7'b1100111,
      OPC_JAL      = 7'b1101111,
      OPC_SYSTEM   = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_t;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_t;

   typedef enum logic [2:0] {
      F3_PRIV  = 3'b000,
      F3_CSRRW = 3'b001,
      F3_CSRRS = 3'b010,
      F3_CSRRC = 3'b011
   } sys_t;

   localparam logic [2:0] F3_ADDI = 3'b000;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      opcode_t    opcode;
   } rtype_t;

   typedef struct packed {
      logic [11:0] imm;
      logic [4:0]  rs1;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      opcode_t     opcode;
   } itype_t;

   typedef struct packed {
      logic [6:0] imm_hi;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] imm_lo;
      opcode_t    opcode;
   } stype_t;

   typedef struct packed {
      logic [19:0] imm;
      logic [4:0]  rd;
      opcode_t     opcode;
   } utype_t;

   typedef struct packed {
      logic [11:0] csr;
      logic [4:0]  rs1;
      sys_t        funct3;
      logic [4:0]  rd;
      opcode_t     opcode;
   } systype_t;

   typedef enum logic [2:0] {
      CMD_LI     = 3'd0,
      CMD_CSRR   = 3'd1,
      CMD_CSRW   = 3'd2,
      CMD_LOAD   = 3'd3,
      CMD_STORE  = 3'd4,
      CMD_FENCEI = 3'd5,
      CMD_NOP    = 3'd6,
      CMD_EBREAK = 3'd7
   } seq_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EMIT1 = 2'd1,
      ST_EMIT2 = 2'd2
   } seq_state_t;

   typedef struct packed {
      seq_cmd_t    cmd;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [11:0] csr;
      logic [2:0]  width;
   } seq_req_t;

   localparam word_t NOP_INSN    = 32'h0000_0013;
   localparam word_t EBREAK_INSN = 32'h0010_0073;
   localparam word_t FENCEI_INSN = 32'h0000_100F;

   // A parked request encodes to NOP, which gives insn its reset value.
   localparam seq_req_t REQ_PARKED = '{cmd: CMD_NOP, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                                       imm: 32'd0, csr: 12'd0, width: 3'd0};

   function automatic logic width_legal(input seq_cmd_t cmd, input logic [2:0] width);
      case (cmd)
         CMD_LOAD:  return width inside {3'(LB), 3'(LH), 3'(LW), 3'(LBU), 3'(LHU)};
         CMD_STORE: return width inside {3'(SB), 3'(SH), 3'(SW)};
         default:   return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/rv32i_insn_encode.sv
// Combinational encoder: turns a latched sequencer request plus a word select
// into an RV32I instruction word, and reports whether the request needs two words.
module rv32i_insn_encode
   import rv32i_types_pkg::*;
#(
   parameter bit SHORT_LI = 1'b1
) (
   input  seq_req_t req,
   input  logic     sel,
   output word_t    word,
   output logic     two_word
);

   logic [11:0] lo;
   logic [19:0] hi;
   logic        fits12;
   itype_t      i_w;
   stype_t      s_w;
   utype_t      u_w;
   systype_t    y_w;

   assign lo     = req.imm[11:0];
   // ADDI sign-extends its immediate, so LUI must pre-compensate when bit 11 is set.
   assign hi     = req.imm[31:12] + 20'(req.imm[11]);
   assign fits12 = (&req.imm[31:11]) | ~(|req.imm[31:11]);

   always_comb begin
      word     = NOP_INSN;
      two_word = 1'b0;
      i_w      = '{imm: lo, rs1: 5'd0, funct3: F3_ADDI, rd: req.rd, opcode: OPC_OP_IMM};
      s_w      = '{imm_hi: lo[11:5], rs2: req.rs2, rs1: req.rs1, funct3: req.width,
                   imm_lo: lo[4:0], opcode: OPC_STORE};
      u_w      = '{imm: hi, rd: req.rd, opcode: OPC_LUI};
      y_w      = '{csr: req.csr, rs1: 5'd0, funct3: F3_CSRRS, rd: req.rd, opcode: OPC_SYSTEM};
      case (req.cmd)
         CMD_LI: begin
            if (SHORT_LI && fits12) begin
               word = i_w;
            end else begin
               two_word = (lo != 12'd0);
               if (sel) begin
                  i_w.rs1 = req.rd;
                  word    = i_w;
               end else begin
                  word = u_w;
               end
            end
         end
         CMD_CSRR: word = y_w;
         CMD_CSRW: begin
            y_w.rs1    = req.rs1;
            y_w.rd     = 5'd0;
            y_w.funct3 = F3_CSRRW;
            word       = y_w;
         end
         CMD_LOAD: begin
            if (width_legal(req.cmd, req.width)) begin
               i_w.rs1    = req.rs1;
               i_w.funct3 = req.width;
               i_w.opcode = OPC_LOAD;
               word       = i_w;
            end else begin
               word = EBREAK_INSN;
            end
         end
         CMD_STORE: word = width_legal(req.cmd, req.width) ? word_t'(s_w) : EBREAK_INSN;
         CMD_FENCEI: word = FENCEI_INSN;
         CMD_NOP:    word = NOP_INSN;
         CMD_EBREAK: word = EBREAK_INSN;
         default:    word = NOP_INSN;
      endcase
   end

endmodule

// File: rtl/rv32i_insn_sequencer.sv
// Expands debug/boot requests into one or two RV32I instruction words for
// injection into fetch, with valid/ready handshakes on both sides.
module rv32i_insn_sequencer
   import rv32i_types_pkg::*;
#(
   parameter bit SHORT_LI = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_cmd,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [31:0] req_imm,
   input  logic [11:0] req_csr,
   input  logic [2:0]  req_width,
   output logic        insn_valid,
   input  logic        insn_ready,
   output word_t       insn,
   output logic        insn_last,
   output logic        req_err,
   output logic        busy,
   output seq_state_t  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // valid never depends on ready, and while valid && !ready the payload holds.

   seq_state_t state;
   seq_req_t   req_q;
   logic       two_word;

   rv32i_insn_encode #(.SHORT_LI(SHORT_LI)) u_encode (
      .req      (req_q),
      .sel      (state == ST_EMIT2),
      .word     (insn),
      .two_word (two_word)
   );

   assign req_ready = (state == ST_IDLE);
   assign insn_last = (state == ST_EMIT2) || ((state == ST_EMIT1) && !two_word);
   assign dbg_state = state;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_IDLE;
         req_q      <= REQ_PARKED;
         insn_valid <= 1'b0;
         busy       <= 1'b0;
         req_err    <= 1'b0;
      end else begin
         req_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_q      <= '{cmd: seq_cmd_t'(req_cmd), rd: req_rd, rs1: req_rs1,
                                  rs2: req_rs2, imm: req_imm, csr: req_csr, width: req_width};
                  req_err    <= !width_legal(seq_cmd_t'(req_cmd), req_width);
                  state      <= ST_EMIT1;
                  insn_valid <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            ST_EMIT1: begin
               if (insn_ready) begin
                  if (two_word) begin
                     state <= ST_EMIT2;
                  end else begin
                     state      <= ST_IDLE;
                     insn_valid <= 1'b0;
                     busy       <= 1'b0;
                  end
               end
            end
            ST_EMIT2: begin
               if (insn_ready) begin
                  state      <= ST_IDLE;
                  insn_valid <= 1'b0;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state      <= ST_IDLE;
               insn_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_insn_sequencer.sv
// Bench for rv32i_insn_sequencer: directed cases plus random requests checked
// against an arithmetic encoding model through an expected-word queue.
module tb_rv32i_insn_sequencer;
   import rv32i_types_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_cmd = 3'd6;
   logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
   logic [31:0] req_imm = '0;
   logic [11:0] req_csr = '0;
   logic [2:0]  req_width = '0;
   logic        insn_valid;
   logic        insn_ready = 1'b0;
   logic [31:0] insn;
   logic        insn_last;
   logic        req_err;
   logic        busy;
   seq_state_t  dbg_state;

   rv32i_insn_sequencer #(.SHORT_LI(1'b1)) dut (
      .CLK        (clk),
      .RST        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_cmd    (req_cmd),
      .req_rd     (req_rd),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_imm    (req_imm),
      .req_csr    (req_csr),
      .req_width  (req_width),
      .insn_valid (insn_valid),
      .insn_ready (insn_ready),
      .insn       (insn),
      .insn_last  (insn_last),
      .req_err    (req_err),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic        exp_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return (32'(imm) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(opc);
   endfunction

   // Reference model: list of words a request should produce.
   task automatic model(input logic [2:0] cmd, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic [11:0] csr,
                        input logic [2:0] width);
      int signed   v;
      int signed   lo;
      logic [31:0] up;
      exp_err = 1'b0;
      v  = imm;
      lo = int'($signed(imm[11:0]));
      case (cmd)
         3'd0: begin
            if (v >= -2048 && v <= 2047) begin
               exp_q.push_back(enc_i(imm[11:0], 5'd0, 3'd0, rd, 7'h13));
            end else begin
               up = imm - 32'(lo);
               exp_q.push_back(up | (32'(rd) << 7) | 32'h37);
               if (imm[11:0] != 12'd0) exp_q.push_back(enc_i(imm[11:0], rd, 3'd0, rd, 7'h13));
            end
         end
         3'd1: exp_q.push_back(enc_i(csr, 5'd0, 3'd2, rd, 7'h73));
         3'd2: exp_q.push_back(enc_i(csr, rs1, 3'd1, 5'd0, 7'h73));
         3'd3: begin
            if (width inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
               exp_q.push_back(enc_i(imm[11:0], rs1, width, rd, 7'h03));
            else begin
               exp_q.push_back(32'h0010_0073);
               exp_err = 1'b1;
            end
         end
         3'd4: begin
            if (width <= 3'd2)
               exp_q.push_back((32'(imm[11:5]) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
                               (32'(width) << 12) | (32'(imm[4:0]) << 7) | 32'h23);
            else begin
               exp_q.push_back(32'h0010_0073);
               exp_err = 1'b1;
            end
         end
         3'd5: exp_q.push_back(32'h0000_100F);
         3'd6: exp_q.push_back(32'h0000_0013);
         default: exp_q.push_back(32'h0010_0073);
      endcase
   endtask

   // ---------------- driver ----------------
   // Called and returning at a negedge.
   task automatic send(input logic [2:0] cmd, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic [11:0] csr,
                       input logic [2:0] width, input int stall_first, input bit rand_ready);
      int n;
      bit rdy;
      check("req_ready_idle", 32'(req_ready), 32'd1);
      check("busy_idle", 32'(busy), 32'd0);
      model(cmd, rd, rs1, rs2, imm, csr, width);
      req_cmd = cmd; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
      req_imm = imm; req_csr = csr; req_width = width;
      req_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      check("req_err_pulse", 32'(req_err), 32'(exp_err));
      n = 0;
      while (exp_q.size() != 0 && n < 64) begin
         check("insn_valid", 32'(insn_valid), 32'd1);
         check("insn", insn, exp_q[0]);
         check("insn_last", 32'(insn_last), 32'(exp_q.size() == 1));
         check("req_ready_busy", 32'(req_ready), 32'd0);
         if (n > 0) check("req_err_clear", 32'(req_err), 32'd0);
         rdy = (n >= stall_first) && (!rand_ready || $urandom_range(0, 2) != 0);
         insn_ready = rdy;
         @(posedge clk); @(negedge clk);
         insn_ready = 1'b0;
         if (rdy) void'(exp_q.pop_front());
         n++;
      end
      if (exp_q.size() != 0) begin
         check("word_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      check("insn_valid_done", 32'(insn_valid), 32'd0);
      check("busy_done", 32'(busy), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [2:0]  r_cmd;
      logic [31:0] r_imm;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      check("rst_insn_valid", 32'(insn_valid), 32'd0);
      check("rst_insn_last", 32'(insn_last), 32'd0);
      check("rst_req_err", 32'(req_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_insn", insn, 32'h0000_0013);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

      // insn_ready without a valid word changes nothing
      insn_ready = 1'b1;
      repeat (2) @(negedge clk);
      insn_ready = 1'b0;
      check("idle_ready_valid", 32'(insn_valid), 32'd0);
      check("idle_ready_rdy", 32'(req_ready), 32'd1);

      // directed encodings from the spec examples
      send(3'd0, 5'd5, 5'd0, 5'd0, 32'h0000_0800, 12'h0, 3'd0, 0, 1'b0);
      send(3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 12'h0, 3'd0, 0, 1'b0);
      send(3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 12'h0, 3'd0, 0, 1'b0);
      send(3'd0, 5'd5, 5'd0, 5'd0, 32'h7FFF_F800, 12'h0, 3'd0, 0, 1'b0);
      send(3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_F800, 12'h0, 3'd0, 0, 1'b0);
      send(3'd0, 5'd5, 5'd0, 5'd0, 32'h0000_07FF, 12'h0, 3'd0, 0, 1'b0);
      send(3'd1, 5'd10, 5'd0, 5'd0, 32'h0, 12'h300, 3'd0, 0, 1'b0);
      send(3'd4, 5'd0, 5'd7, 5'd6, 32'h0000_0010, 12'h0, 3'd2, 0, 1'b0);
      send(3'd5, 5'd0, 5'd0, 5'd0, 32'h0, 12'h0, 3'd0, 0, 1'b0);
      send(3'd2, 5'd3, 5'd9, 5'd0, 32'h0, 12'h7C0, 3'd0, 0, 1'b0);
      send(3'd7, 5'd0, 5'd0, 5'd0, 32'h0, 12'h0, 3'd0, 0, 1'b0);

      // backpressure on a two-word LI, then illegal load width
      send(3'd0, 5'd5, 5'd0, 5'd0, 32'h0000_0800, 12'h0, 3'd0, 5, 1'b0);
      send(3'd3, 5'd1, 5'd2, 5'd0, 32'h0000_0004, 12'h0, 3'd3, 0, 1'b0);
      send(3'd4, 5'd0, 5'd2, 5'd3, 32'h0000_0FFF, 12'h0, 3'd5, 2, 1'b0);

      // reset in the middle of a two-word LI
      req_cmd = 3'd0; req_rd = 5'd5; req_imm = 32'h0000_0800; req_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      check("pre_rst_valid", 32'(insn_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      check("mid_rst_valid", 32'(insn_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_req_ready", 32'(req_ready), 32'd1);
      check("mid_rst_insn", insn, 32'h0000_0013);
      @(negedge clk);
      check("mid_rst_no_word2", 32'(insn_valid), 32'd0);
      send(3'd6, 5'd0, 5'd0, 5'd0, 32'h0, 12'h0, 3'd0, 0, 1'b0);

      // reset coincident with a request: not accepted
      rst = 1'b1; req_cmd = 3'd1; req_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      check("rst_req_valid", 32'(insn_valid), 32'd0);
      check("rst_req_busy", 32'(busy), 32'd0);

      // random requests with random backpressure
      for (int i = 0; i < 150; i++) begin
         r_cmd = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: r_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1: r_imm = $urandom;
            2: r_imm = $urandom & 32'hFFFF_F000;
            default: r_imm = $urandom | 32'h0000_0800;
         endcase
         send(r_cmd, 5'($urandom), 5'($urandom), 5'($urandom), r_imm, 12'($urandom),
              3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'b1);
      end

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
